// File: rtl/gpu_blitter.sv
// gpu_blitter: copies a rectangular excerpt of a 16-bit image from memory
// into the framebuffer (with optional mirroring and colour-key transparency),
// or fills a rectangle with a solid colour. Off-screen pixels are still
// walked, but they are never written.
module gpu_blitter #(
    parameter int FB_WIDTH  = 400,
    parameter int FB_HEIGHT = 240,
    parameter int CW        = $clog2(FB_WIDTH > FB_HEIGHT ? FB_WIDTH : FB_HEIGHT) + 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [15:0]                  mem_data,
    input  logic                         mem_valid,
    output logic [31:0]                  mem_addr,
    output logic                         mem_read,
    input  logic [31:0]                  ctrl_address,
    input  logic [15:0]                  ctrl_address_x,
    input  logic [15:0]                  ctrl_address_y,
    input  logic [15:0]                  ctrl_image_width,
    input  logic [CW-1:0]                ctrl_width,
    input  logic [CW-1:0]                ctrl_height,
    input  logic [CW-1:0]                ctrl_x,
    input  logic [CW-1:0]                ctrl_y,
    input  logic                         ctrl_flip_x,
    input  logic                         ctrl_flip_y,
    input  logic [15:0]                  ctrl_fill_color,
    input  logic                         ctrl_draw,
    input  logic                         ctrl_fill,
    output logic                         ctrl_busy,
    output logic [$clog2(FB_WIDTH):0]    fb_x,
    output logic [$clog2(FB_HEIGHT):0]   fb_y,
    output logic [15:0]                  fb_color,
    output logic                         fb_write
);

    localparam int XW = $clog2(FB_WIDTH) + 1;
    localparam int YW = $clog2(FB_HEIGHT) + 1;

    typedef enum logic [1:0] {IDLE, DRAW, FILL, DONE} state_t;

    state_t        state;
    logic          draw_prev;
    logic          fill_prev;
    logic          armed;

    logic [31:0]   lat_address;
    logic [15:0]   lat_off_x;
    logic [15:0]   lat_off_y;
    logic [15:0]   lat_stride;
    logic [CW-1:0] lat_w;
    logic [CW-1:0] lat_h;
    logic [CW-1:0] lat_x;
    logic [CW-1:0] lat_y;
    logic          lat_flip_x;
    logic          lat_flip_y;
    logic [15:0]   lat_color;

    logic [CW-1:0] px;
    logic [CW-1:0] py;

    logic          draw_edge;
    logic          fill_edge;
    logic          last_px;
    logic          last_pix;
    logic [CW-1:0] nxt_px;
    logic [CW-1:0] nxt_py;
    logic [CW-1:0] scr_x;
    logic [CW-1:0] scr_y;
    logic          visible;

    // Byte address of a source pixel; the mirrored coordinate is taken
    // relative to the excerpt, and everything wraps modulo 2^32.
    function automatic logic [31:0] calc_addr(
        input logic [31:0]   base,
        input logic [15:0]   off_x,
        input logic [15:0]   off_y,
        input logic [15:0]   stride,
        input logic [CW-1:0] w,
        input logic [CW-1:0] h,
        input logic          fx,
        input logic          fy,
        input logic [CW-1:0] cx,
        input logic [CW-1:0] cy
    );
        logic [31:0] src_x;
        logic [31:0] src_y;
        src_x = fx ? (32'(w) - 32'd1 - 32'(cx)) : 32'(cx);
        src_y = fy ? (32'(h) - 32'd1 - 32'(cy)) : 32'(cy);
        return base + 32'd2 * ((32'(off_x) + src_x) + (32'(off_y) + src_y) * 32'(stride));
    endfunction

    // Edge detection, scan-position bookkeeping and screen-space clipping.
    // The armed flag keeps a request that was held high through reset from
    // being mistaken for a fresh edge once reset is released.
    always_comb begin
        draw_edge = ctrl_draw & ~draw_prev & armed;
        fill_edge = ctrl_fill & ~fill_prev & armed;
        last_px   = (px == lat_w - CW'(1));
        last_pix  = last_px && (py == lat_h - CW'(1));
        nxt_px    = last_px ? '0 : px + CW'(1);
        nxt_py    = last_px ? py + CW'(1) : py;
        scr_x     = lat_x + px;
        scr_y     = lat_y + py;
        visible   = !scr_x[CW-1] && (scr_x < CW'(FB_WIDTH)) &&
                    !scr_y[CW-1] && (scr_y < CW'(FB_HEIGHT));
    end

    // Command sequencer: accepts one command from IDLE, walks its pixels,
    // and produces registered memory-request and framebuffer-write outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            draw_prev   <= 1'b0;
            fill_prev   <= 1'b0;
            armed       <= 1'b0;
            lat_address <= '0;
            lat_off_x   <= '0;
            lat_off_y   <= '0;
            lat_stride  <= '0;
            lat_w       <= '0;
            lat_h       <= '0;
            lat_x       <= '0;
            lat_y       <= '0;
            lat_flip_x  <= 1'b0;
            lat_flip_y  <= 1'b0;
            lat_color   <= '0;
            px          <= '0;
            py          <= '0;
            mem_read    <= 1'b0;
            mem_addr    <= '0;
            ctrl_busy   <= 1'b0;
            fb_write    <= 1'b0;
            fb_x        <= '0;
            fb_y        <= '0;
            fb_color    <= '0;
        end else begin
            draw_prev <= ctrl_draw;
            fill_prev <= ctrl_fill;
            armed     <= 1'b1;
            fb_write  <= 1'b0;
            case (state)
                IDLE: begin
                    if (draw_edge || fill_edge) begin
                        lat_address <= ctrl_address;
                        lat_off_x   <= ctrl_address_x;
                        lat_off_y   <= ctrl_address_y;
                        lat_stride  <= ctrl_image_width;
                        lat_w       <= ctrl_width;
                        lat_h       <= ctrl_height;
                        lat_x       <= ctrl_x;
                        lat_y       <= ctrl_y;
                        lat_flip_x  <= ctrl_flip_x;
                        lat_flip_y  <= ctrl_flip_y;
                        lat_color   <= ctrl_fill_color;
                        px          <= '0;
                        py          <= '0;
                        ctrl_busy   <= 1'b1;
                        if (ctrl_width == '0 || ctrl_height == '0) begin
                            state <= DONE;
                        end else if (draw_edge) begin
                            state    <= DRAW;
                            mem_read <= 1'b1;
                            mem_addr <= calc_addr(ctrl_address, ctrl_address_x, ctrl_address_y,
                                                  ctrl_image_width, ctrl_width, ctrl_height,
                                                  ctrl_flip_x, ctrl_flip_y, '0, '0);
                        end else begin
                            state <= FILL;
                        end
                    end
                end
                DRAW: begin
                    if (mem_valid) begin
                        if (visible && mem_data[0]) begin
                            fb_write <= 1'b1;
                            fb_x     <= scr_x[XW-1:0];
                            fb_y     <= scr_y[YW-1:0];
                            fb_color <= mem_data;
                        end
                        if (last_pix) begin
                            state    <= DONE;
                            mem_read <= 1'b0;
                            mem_addr <= '0;
                        end else begin
                            px       <= nxt_px;
                            py       <= nxt_py;
                            mem_addr <= calc_addr(lat_address, lat_off_x, lat_off_y, lat_stride,
                                                  lat_w, lat_h, lat_flip_x, lat_flip_y,
                                                  nxt_px, nxt_py);
                        end
                    end
                end
                FILL: begin
                    if (visible) begin
                        fb_write <= 1'b1;
                        fb_x     <= scr_x[XW-1:0];
                        fb_y     <= scr_y[YW-1:0];
                        fb_color <= lat_color;
                    end
                    if (last_pix) begin
                        state <= DONE;
                    end else begin
                        px <= nxt_px;
                        py <= nxt_py;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    ctrl_busy <= 1'b0;
                    px        <= '0;
                    py        <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpu_blitter.sv
// tb_gpu_blitter: drives draw/fill commands into gpu_blitter while acting as
// the memory, and compares the read addresses, framebuffer writes and busy
// duration against a pixel-by-pixel reference model of each command.
module tb_gpu_blitter;

    localparam int FB_WIDTH  = 400;
    localparam int FB_HEIGHT = 240;
    localparam int CW        = $clog2(FB_WIDTH > FB_HEIGHT ? FB_WIDTH : FB_HEIGHT) + 2;
    localparam int XW        = $clog2(FB_WIDTH) + 1;
    localparam int YW        = $clog2(FB_HEIGHT) + 1;

    logic          clk;
    logic          reset;
    logic [15:0]   mem_data;
    logic          mem_valid;
    logic [31:0]   mem_addr;
    logic          mem_read;
    logic [31:0]   ctrl_address;
    logic [15:0]   ctrl_address_x;
    logic [15:0]   ctrl_address_y;
    logic [15:0]   ctrl_image_width;
    logic [CW-1:0] ctrl_width;
    logic [CW-1:0] ctrl_height;
    logic [CW-1:0] ctrl_x;
    logic [CW-1:0] ctrl_y;
    logic          ctrl_flip_x;
    logic          ctrl_flip_y;
    logic [15:0]   ctrl_fill_color;
    logic          ctrl_draw;
    logic          ctrl_fill;
    logic          ctrl_busy;
    logic [XW-1:0] fb_x;
    logic [YW-1:0] fb_y;
    logic [15:0]   fb_color;
    logic          fb_write;

    gpu_blitter #(
        .FB_WIDTH (FB_WIDTH),
        .FB_HEIGHT(FB_HEIGHT),
        .CW       (CW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .mem_data        (mem_data),
        .mem_valid       (mem_valid),
        .mem_addr        (mem_addr),
        .mem_read        (mem_read),
        .ctrl_address    (ctrl_address),
        .ctrl_address_x  (ctrl_address_x),
        .ctrl_address_y  (ctrl_address_y),
        .ctrl_image_width(ctrl_image_width),
        .ctrl_width      (ctrl_width),
        .ctrl_height     (ctrl_height),
        .ctrl_x          (ctrl_x),
        .ctrl_y          (ctrl_y),
        .ctrl_flip_x     (ctrl_flip_x),
        .ctrl_flip_y     (ctrl_flip_y),
        .ctrl_fill_color (ctrl_fill_color),
        .ctrl_draw       (ctrl_draw),
        .ctrl_fill       (ctrl_fill),
        .ctrl_busy       (ctrl_busy),
        .fb_x            (fb_x),
        .fb_y            (fb_y),
        .fb_color        (fb_color),
        .fb_write        (fb_write)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    int          cmd_mode;
    int          cmd_w;
    int          cmd_h;
    int          cmd_x;
    int          cmd_y;
    int          cmd_delay;
    logic [31:0] cmd_base;
    logic [15:0] cmd_ax;
    logic [15:0] cmd_ay;
    logic [15:0] cmd_stride;
    logic [15:0] cmd_color;
    logic        cmd_fx;
    logic        cmd_fy;

    logic [15:0] mem_override [logic [31:0]];
    logic [31:0] exp_reads[$];
    logic [31:0] obs_reads[$];
    logic [47:0] exp_writes[$];
    logic [47:0] obs_writes[$];
    int          exp_busy;
    int          obs_busy;
    int          hold_errs;

    function automatic logic [15:0] mem_value(input logic [31:0] a);
        logic [31:0] h;
        if (mem_override.exists(a)) return mem_override[a];
        h = a * 32'h9E3779B1;
        return h[31:16];
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic buildModel();
        int sx, sy, sxp, syp;
        logic [31:0] addr;
        logic [15:0] d;
        bit vis;
        exp_reads.delete();
        exp_writes.delete();
        exp_busy = 1;
        if (cmd_w == 0 || cmd_h == 0) return;
        for (int yy = 0; yy < cmd_h; yy++) begin
            for (int xx = 0; xx < cmd_w; xx++) begin
                sx  = cmd_fx ? cmd_w - 1 - xx : xx;
                sy  = cmd_fy ? cmd_h - 1 - yy : yy;
                sxp = cmd_x + xx;
                syp = cmd_y + yy;
                vis = (sxp >= 0) && (sxp < FB_WIDTH) && (syp >= 0) && (syp < FB_HEIGHT);
                if (cmd_mode != 1) begin
                    addr = cmd_base + 32'd2 * (32'(cmd_ax) + 32'(sx) + (32'(cmd_ay) + 32'(sy)) * 32'(cmd_stride));
                    d = mem_value(addr);
                    exp_reads.push_back(addr);
                    exp_busy += cmd_delay + 1;
                    if (vis && d[0]) exp_writes.push_back({16'(sxp), 16'(syp), d});
                end else begin
                    exp_busy += 1;
                    if (vis) exp_writes.push_back({16'(sxp), 16'(syp), cmd_color});
                end
            end
        end
    endtask

    task automatic applyStimulus(input string tag);
        int wait_cnt;
        int idle_busy;
        bit held;
        bit done;
        logic [31:0] held_addr;
        int n;
        @(negedge clk);
        buildModel();
        obs_reads.delete();
        obs_writes.delete();
        obs_busy  = 0;
        hold_errs = 0;
        wait_cnt  = 0;
        held      = 0;
        held_addr = '0;
        done      = 0;
        ctrl_address     = cmd_base;
        ctrl_address_x   = cmd_ax;
        ctrl_address_y   = cmd_ay;
        ctrl_image_width = cmd_stride;
        ctrl_width       = CW'(cmd_w);
        ctrl_height      = CW'(cmd_h);
        ctrl_x           = CW'(cmd_x);
        ctrl_y           = CW'(cmd_y);
        ctrl_flip_x      = cmd_fx;
        ctrl_flip_y      = cmd_fy;
        ctrl_fill_color  = cmd_color;
        ctrl_draw        = (cmd_mode != 1);
        ctrl_fill        = (cmd_mode != 0);
        @(negedge clk);
        ctrl_draw        = 1'b0;
        ctrl_fill        = 1'b0;
        ctrl_address     = $urandom;
        ctrl_address_x   = 16'($urandom);
        ctrl_address_y   = 16'($urandom);
        ctrl_image_width = 16'($urandom);
        ctrl_width       = CW'($urandom);
        ctrl_height      = CW'($urandom);
        ctrl_x           = CW'($urandom);
        ctrl_y           = CW'($urandom);
        ctrl_flip_x      = 1'($urandom);
        ctrl_flip_y      = 1'($urandom);
        ctrl_fill_color  = 16'($urandom);
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (fb_write) obs_writes.push_back({16'(fb_x), 16'(fb_y), fb_color});
            if (!ctrl_busy) begin
                done = 1;
                break;
            end
            obs_busy++;
            if (mem_read) begin
                if (held && mem_addr !== held_addr) hold_errs++;
                if (wait_cnt >= cmd_delay) begin
                    mem_valid = 1'b1;
                    mem_data  = mem_value(mem_addr);
                    obs_reads.push_back(mem_addr);
                    wait_cnt  = 0;
                    held      = 0;
                end else begin
                    mem_valid = 1'b0;
                    mem_data  = 16'($urandom);
                    wait_cnt++;
                    held      = 1;
                    held_addr = mem_addr;
                end
            end else begin
                mem_valid = 1'($urandom);
                mem_data  = 16'($urandom);
                wait_cnt  = 0;
                held      = 0;
            end
            if (cyc == 1) begin
                ctrl_draw = 1'b1;
                ctrl_fill = 1'b1;
            end
            if (cyc == 2) begin
                ctrl_draw = 1'b0;
                ctrl_fill = 1'b0;
            end
            @(negedge clk);
        end
        ctrl_draw = 1'b0;
        ctrl_fill = 1'b0;
        mem_valid = 1'b0;
        checkOutput({tag, "_completed"}, 64'(done), 64'd1);
        idle_busy = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (ctrl_busy) idle_busy++;
            if (fb_write) obs_writes.push_back({16'(fb_x), 16'(fb_y), fb_color});
        end
        checkOutput({tag, "_idle_after"}, 64'(idle_busy), 64'd0);
        checkOutput({tag, "_busy_cycles"}, 64'(obs_busy), 64'(exp_busy));
        checkOutput({tag, "_addr_hold"}, 64'(hold_errs), 64'd0);
        checkOutput({tag, "_read_count"}, 64'(obs_reads.size()), 64'(exp_reads.size()));
        n = (obs_reads.size() < exp_reads.size()) ? obs_reads.size() : exp_reads.size();
        for (int i = 0; i < n; i++)
            checkOutput($sformatf("%s_read%0d", tag, i), 64'(obs_reads[i]), 64'(exp_reads[i]));
        checkOutput({tag, "_write_count"}, 64'(obs_writes.size()), 64'(exp_writes.size()));
        n = (obs_writes.size() < exp_writes.size()) ? obs_writes.size() : exp_writes.size();
        for (int i = 0; i < n; i++)
            checkOutput($sformatf("%s_write%0d", tag, i), 64'(obs_writes[i]), 64'(exp_writes[i]));
    endtask

    // Directed scenarios first, then randomized commands, then the summary.
    initial begin
        logic [15:0] found_col;
        int cnt_busy;
        int cnt_write;

        reset = 1'b1;
        mem_data = '0;
        mem_valid = 1'b0;
        ctrl_address = '0;
        ctrl_address_x = '0;
        ctrl_address_y = '0;
        ctrl_image_width = '0;
        ctrl_width = '0;
        ctrl_height = '0;
        ctrl_x = '0;
        ctrl_y = '0;
        ctrl_flip_x = 1'b0;
        ctrl_flip_y = 1'b0;
        ctrl_fill_color = '0;
        ctrl_draw = 1'b0;
        ctrl_fill = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", 64'(ctrl_busy), 64'd0);
        checkOutput("reset_mem_read", 64'(mem_read), 64'd0);
        checkOutput("reset_mem_addr", 64'(mem_addr), 64'd0);
        checkOutput("reset_fb_write", 64'(fb_write), 64'd0);
        checkOutput("reset_fb_x", 64'(fb_x), 64'd0);
        checkOutput("reset_fb_y", 64'(fb_y), 64'd0);
        checkOutput("reset_fb_color", 64'(fb_color), 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Basic 3x2 draw, every datum opaque.
        for (int i = 0; i < 16; i++) mem_override[32'h1000 + 32'(2 * i)] = 16'h0001;
        cmd_mode = 0; cmd_w = 3; cmd_h = 2; cmd_x = 10; cmd_y = 5; cmd_delay = 0;
        cmd_base = 32'h1000; cmd_ax = 0; cmd_ay = 0; cmd_stride = 8;
        cmd_color = 16'h0; cmd_fx = 0; cmd_fy = 0;
        applyStimulus("draw3x2");
        checkOutput("draw3x2_first_addr", 64'(obs_reads.size() > 0 ? obs_reads[0] : 32'hFFFF_FFFF), 64'h1000);
        checkOutput("draw3x2_last_addr", 64'(obs_reads.size() > 0 ? obs_reads[obs_reads.size() - 1] : 32'hFFFF_FFFF), 64'h1014);
        checkOutput("draw3x2_writes", 64'(obs_writes.size()), 64'd6);

        // Same draw mirrored both ways.
        mem_override[32'h1014] = 16'h1235;
        cmd_fx = 1; cmd_fy = 1;
        applyStimulus("draw_flip");
        checkOutput("draw_flip_first_addr", 64'(obs_reads.size() > 0 ? obs_reads[0] : 32'hFFFF_FFFF), 64'h1014);
        checkOutput("draw_flip_last_addr", 64'(obs_reads.size() > 0 ? obs_reads[obs_reads.size() - 1] : 32'hFFFF_FFFF), 64'h1000);
        found_col = '0;
        foreach (obs_writes[i])
            if (obs_writes[i][47:16] == {16'd10, 16'd5}) found_col = obs_writes[i][15:0];
        checkOutput("draw_flip_color_at_10_5", 64'(found_col), 64'h1235);

        // Clipped fill straddling the left and bottom edges.
        cmd_mode = 1; cmd_w = 4; cmd_h = 4; cmd_x = -2; cmd_y = 238; cmd_delay = 0;
        cmd_color = 16'hF800; cmd_fx = 0; cmd_fy = 0;
        applyStimulus("fill_clip");
        checkOutput("fill_clip_writes", 64'(obs_writes.size()), 64'd4);
        checkOutput("fill_clip_busy", 64'(obs_busy), 64'd17);

        // Slow memory with a transparent second pixel.
        mem_override[32'h2000] = 16'h0003;
        mem_override[32'h2002] = 16'h0000;
        cmd_mode = 0; cmd_w = 2; cmd_h = 1; cmd_x = 20; cmd_y = 30; cmd_delay = 5;
        cmd_base = 32'h2000; cmd_ax = 0; cmd_ay = 0; cmd_stride = 4;
        applyStimulus("draw_slow");
        checkOutput("draw_slow_writes", 64'(obs_writes.size()), 64'd1);
        checkOutput("draw_slow_busy", 64'(obs_busy), 64'd13);

        // Zero-width draw and a simultaneous draw+fill edge.
        cmd_mode = 0; cmd_w = 0; cmd_h = 3; cmd_delay = 0;
        applyStimulus("draw_zero");
        checkOutput("draw_zero_busy", 64'(obs_busy), 64'd1);
        cmd_mode = 2; cmd_w = 2; cmd_h = 2; cmd_x = 50; cmd_y = 60; cmd_delay = 1;
        cmd_base = 32'h3000; cmd_stride = 16; cmd_color = 16'hFFFF;
        applyStimulus("draw_and_fill");

        // Reset in the middle of a fill, with the fill request still high.
        @(negedge clk);
        ctrl_width = CW'(8); ctrl_height = CW'(8); ctrl_x = '0; ctrl_y = '0;
        ctrl_fill_color = 16'h07E0;
        ctrl_fill = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midreset_busy", 64'(ctrl_busy), 64'd0);
        checkOutput("midreset_fb_write", 64'(fb_write), 64'd0);
        reset = 1'b0;
        cnt_busy = 0;
        cnt_write = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (ctrl_busy) cnt_busy++;
            if (fb_write) cnt_write++;
        end
        checkOutput("midreset_no_restart", 64'(cnt_busy), 64'd0);
        checkOutput("midreset_no_write", 64'(cnt_write), 64'd0);
        ctrl_fill = 1'b0;
        repeat (2) @(negedge clk);
        cmd_mode = 1; cmd_w = 3; cmd_h = 2; cmd_x = 100; cmd_y = 100; cmd_color = 16'h0042;
        applyStimulus("fill_after_reset");

        // Randomized commands near the screen edges.
        mem_override.delete();
        for (int t = 0; t < 12; t++) begin
            cmd_mode   = $urandom_range(0, 2);
            cmd_w      = $urandom_range(0, 6);
            cmd_h      = $urandom_range(1, 5);
            cmd_x      = int'($urandom_range(0, 440)) - 20;
            cmd_y      = int'($urandom_range(0, 260)) - 10;
            cmd_delay  = $urandom_range(0, 3);
            cmd_base   = $urandom;
            cmd_ax     = 16'($urandom_range(0, 1000));
            cmd_ay     = 16'($urandom_range(0, 1000));
            cmd_stride = 16'($urandom);
            cmd_color  = 16'($urandom);
            cmd_fx     = 1'($urandom);
            cmd_fy     = 1'($urandom);
            applyStimulus($sformatf("rand%0d", t));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/gpu_blitter.md
GPU_BLITTER -- requirements
Module: gpu_blitter

Interface
REQ-001 SHALL have parameter FB_WIDTH, default 400: framebuffer width in pixels.
REQ-002 SHALL have parameter FB_HEIGHT, default 240: framebuffer height in pixels.
REQ-003 SHALL have parameter CW, default $clog2(FB_WIDTH>FB_HEIGHT?FB_WIDTH:FB_HEIGHT)+2: signed screen-coordinate width.
REQ-004 SHALL have ports:
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- mem_data  in  16  read data.
- mem_valid  in  1  mem_data valid this cycle.
- mem_addr  out  32  byte address of the pixel being read.
- mem_read  out  1  read request.
- ctrl_address  in  32  image base byte address.
- ctrl_address_x  in  16  source x offset, in pixels.
- ctrl_address_y  in  16  source y offset, in pixels.
- ctrl_image_width  in  16  source stride, in pixels.
- ctrl_width  in  CW  excerpt width, unsigned.
- ctrl_height  in  CW  excerpt height, unsigned.
- ctrl_x  in  CW  signed left screen position.
- ctrl_y  in  CW  signed top screen position.
- ctrl_flip_x  in  1  mirror horizontally.
- ctrl_flip_y  in  1  mirror vertically.
- ctrl_fill_color  in  16  rectangle fill colour.
- ctrl_draw  in  1  rising edge starts image draw.
- ctrl_fill  in  1  rising edge starts rectangle fill.
- ctrl_busy  out  1  command in progress.
- fb_x  out  $clog2(FB_WIDTH)+1  pixel x.
- fb_y  out  $clog2(FB_HEIGHT)+1  pixel y.
- fb_color  out  16  pixel colour.
- fb_write  out  1  write strobe.

Function
REQ-005 SHALL detect commands on 0->1 edges of ctrl_draw/ctrl_fill, sampled against their previous-cycle value.
REQ-006 SHALL accept a command only in IDLE; edges while busy SHALL be discarded, not queued.
REQ-007 SHALL give draw priority when both edges occur in the same cycle; the fill edge is dropped.
REQ-008 SHALL latch all ctrl_* operands on the acceptance cycle; later input changes SHALL NOT affect the running command.
REQ-009 SHALL implement states IDLE, DRAW, FILL, DONE.
- IDLE->DRAW/FILL on an accepted edge.
- DRAW/FILL->DONE after the last pixel (pixel counter px,py at width-1, height-1).
- DONE->IDLE after one cycle.
REQ-010 SHALL assert ctrl_busy registered, from the cycle after the accepted edge through the DONE cycle inclusive.
REQ-011 SHALL go IDLE->DONE directly when the latched width or height is 0: no mem_read, no fb_write, busy for exactly one cycle.
REQ-012 SHALL scan pixels row-major: px 0..w-1 inner, py 0..h-1 outer.
REQ-013 SHALL compute source coordinates sx = flip_x ? w-1-px : px, sy = flip_y ? h-1-py : py.
REQ-014 SHALL drive mem_addr = ctrl_address + 2*((ax+sx) + (ay+sy)*stride), computed in 32 bits and wrapping modulo 2^32.
REQ-015 In DRAW, SHALL hold mem_read=1 and mem_addr stable until mem_valid, then advance to the next pixel in the following cycle; mem_valid outside DRAW SHALL be ignored.
REQ-016 In FILL, SHALL advance one pixel per cycle with mem_read=0.
REQ-017 SHALL compute screen position X = ctrl_x+px, Y = ctrl_y+py as signed CW-bit values.
REQ-018 SHALL treat a pixel as visible iff 0<=X<FB_WIDTH and 0<=Y<FB_HEIGHT; invisible pixels SHALL still be fetched/consumed but not written.
REQ-019 SHALL register fb outputs: fb_write pulses one cycle after the pixel resolves (mem_valid in DRAW, each cycle in FILL), with fb_x/fb_y/fb_color valid in that same cycle.
REQ-020 SHALL suppress fb_write in DRAW when mem_data[0]==0 (transparent); FILL SHALL write regardless of colour bit 0.
REQ-021 SHALL set fb_color to mem_data in DRAW and to the latched ctrl_fill_color in FILL.
REQ-022 SHALL deassert ctrl_busy no earlier than the cycle after the final fb_write.

Reset
REQ-023 On reset SHALL enter IDLE with mem_read=0, mem_addr=0, ctrl_busy=0, fb_write=0, fb_x=0, fb_y=0, fb_color=0, counters 0 and edge history 0.
REQ-024 Reset mid-command SHALL abort the command immediately, with no further fb_write; a ctrl_draw/ctrl_fill held high through reset SHALL NOT start a command when reset falls.

Verification
REQ-025 Draw 3x2 at (10,5), base 0x1000, stride 8, offsets 0/0, mem_valid every cycle, data 0x0001 -> 6 writes at (10..12,5..6); addresses 0x1000,0x1002,0x1004,0x1010,0x1012,0x1014.
REQ-026 Same draw with flip_x=1, flip_y=1 -> first address 0x1014, last 0x1000; the pixel written at (10,5) carries the data read from 0x1014.
REQ-027 Fill 4x4 at (-2,238), colour 0xF800 -> writes only at x 0..1, y 238..239 (4 writes); busy for 16+1 cycles.
REQ-028 Draw 2x1 with mem_valid delayed 5 cycles per pixel, second datum 0x0000 -> mem_addr held during each wait; exactly 1 fb_write.
REQ-029 Width 0 draw -> busy exactly 1 cycle, no mem_read, no fb_write; a simultaneous draw+fill edge -> only the draw runs.
REQ-030 Reset asserted mid-fill -> next cycle busy=0 and fb_write=0; a new fill afterwards completes normally.
